// File: rtl/mse_reporter_pkg.sv
// Shared types and constants for the MSE result reporter: FSM encoding,
// frame geometry and default header value.
package mse_reporter_pkg;

    localparam int          DEF_NUM_SYS    = 2;
    localparam int          DEF_DATA_W     = 64;
    localparam int          DEF_BYTE_GAP   = 8700;
    localparam logic [7:0]  DEF_HDR_BYTE   = 8'hA5;
    localparam int          BYTES_PER_WORD = DEF_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_e;

    // Header byte + payload bytes + trailing XOR checksum byte.
    function automatic int frame_len(input int num_sys, input int data_w);
        return 2 + num_sys * (data_w / 8);
    endfunction

endpackage

// File: rtl/mse_reporter_if.sv
// Result capture and UART byte-stream signals of the MSE reporter.
// The slave modport is the reporter side, the master modport the environment.
interface mse_reporter_if
    import mse_reporter_pkg::*;
#(
    parameter int NUM_SYS = DEF_NUM_SYS,
    parameter int DATA_W  = DEF_DATA_W
);
    logic                            start;
    logic [NUM_SYS-1:0][DATA_W-1:0]  mse_data;
    logic [NUM_SYS-1:0]              mse_valid;
    logic                            com_txvalid;
    logic [7:0]                      com_txdata;
    logic                            busy;
    logic                            overrun;

    modport master (
        output start, mse_data, mse_valid,
        input  com_txvalid, com_txdata, busy, overrun
    );

    modport slave (
        input  start, mse_data, mse_valid,
        output com_txvalid, com_txdata, busy, overrun
    );
endinterface

// File: rtl/mse_reporter_tx_byte_pacer.sv
// Inter-byte gap timer: loaded on each byte launch, o_done pulses BYTE_GAP-1
// cycles later so that launches land exactly BYTE_GAP cycles apart.
module tx_byte_pacer
    import mse_reporter_pkg::*;
#(
    parameter int BYTE_GAP = DEF_BYTE_GAP
) (
    input  logic clk,
    input  logic rst,
    input  logic i_launch,
    output logic o_done
);
    localparam int CNT_W = (BYTE_GAP > 2) ? $clog2(BYTE_GAP) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_active;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_launch) begin
            r_cnt    <= CNT_W'(BYTE_GAP - 2);
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_cnt == '0) r_active <= 1'b0;
            else             r_cnt    <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = r_active && (r_cnt == '0);

endmodule

// File: rtl/mse_reporter.sv
// Captures one MSE word per system, snapshots a full set and streams it as a
// framed, XOR-checksummed byte sequence paced for a ready-less UART.
module mse_reporter
    import mse_reporter_pkg::*;
#(
    parameter int         NUM_SYS  = DEF_NUM_SYS,
    parameter int         DATA_W   = DEF_DATA_W,
    parameter int         BYTE_GAP = DEF_BYTE_GAP,
    parameter logic [7:0] HDR_BYTE = DEF_HDR_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    mse_reporter_if.slave     bus
);
    localparam int FLEN  = frame_len(NUM_SYS, DATA_W);
    localparam int IDX_W = $clog2(FLEN);
    localparam int PAY_W = NUM_SYS * DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FLEN - 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_SEND = SEND;
    localparam logic [1:0] S_WAIT = WAIT;

    logic [NUM_SYS-1:0][DATA_W-1:0] r_cap;
    logic [NUM_SYS-1:0][DATA_W-1:0] r_snap;
    logic [NUM_SYS-1:0]             r_flag;
    logic                           r_overrun;
    logic [1:0]                     r_state;
    logic [IDX_W-1:0]               r_byte_idx;
    logic [7:0]                     r_last_byte;

    logic             w_consume;
    logic             w_gap_done;
    logic [PAY_W-1:0] w_flat;
    logic [7:0]       w_csum;
    logic [7:0]       w_byte;

    assign w_consume = (r_state == S_IDLE) && (&r_flag);

    // NOTE: the capture words are reset along with the flags, so a frame can
    // never carry stale power-up contents, even though flags gate their use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap     <= '0;
            r_flag    <= '0;
            r_overrun <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SYS; i++) begin
                if (bus.start) begin
                    r_flag[i] <= 1'b0;
                end else if (bus.mse_valid[i]) begin
                    r_cap[i]  <= bus.mse_data[i];
                    r_flag[i] <= 1'b1;
                end else if (w_consume) begin
                    r_flag[i] <= 1'b0;
                end
            end
            if (bus.start)
                r_overrun <= 1'b0;
            else if (|(bus.mse_valid & r_flag & ~{NUM_SYS{w_consume}}))
                r_overrun <= 1'b1;
        end
    end

    // Sys0 occupies the most significant bytes so payload is MSB-first in order.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value held and infer a latch.
    always_comb begin
        w_flat = '0;
        w_csum = '0;
        w_byte = HDR_BYTE;
        for (int i = 0; i < NUM_SYS; i++)
            w_flat[(NUM_SYS-1-i)*DATA_W +: DATA_W] = r_snap[i];
        for (int p = 0; p < PAY_W / 8; p++)
            w_csum = w_csum ^ w_flat[8*p +: 8];
        if (r_byte_idx == LAST_IDX)
            w_byte = w_csum;
        else if (r_byte_idx != '0)
            w_byte = w_flat[PAY_W - 8*int'(r_byte_idx) +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_snap      <= '0;
            r_byte_idx  <= '0;
            r_last_byte <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_consume) begin
                    r_snap     <= r_cap;
                    r_byte_idx <= '0;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    r_last_byte <= w_byte;
                    r_state     <= S_WAIT;
                end
                S_WAIT: if (w_gap_done) begin
                    if (r_byte_idx == LAST_IDX) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_byte_idx <= r_byte_idx + IDX_W'(1);
                        r_state    <= S_SEND;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    tx_byte_pacer #(.BYTE_GAP(BYTE_GAP)) u_pacer (
        .clk      (clk),
        .rst      (rst),
        .i_launch (r_state == S_SEND),
        .o_done   (w_gap_done)
    );

    // Outside SEND the data line repeats the last launched byte.
    assign bus.com_txvalid = (r_state == S_SEND);
    assign bus.com_txdata  = (r_state == S_SEND) ? w_byte : r_last_byte;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_mse_reporter.sv
// Self-checking bench for mse_reporter: directed scenarios plus random traffic,
// compared each cycle against a frame-scheduling reference model.
module tb_mse_reporter;

    localparam int         NS   = 2;
    localparam int         DW   = 64;
    localparam int         G    = 4;
    localparam logic [7:0] HDR  = 8'hA5;
    localparam int         FLEN = 2 + NS * DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mse_reporter_if #(.NUM_SYS(NS), .DATA_W(DW)) bus ();

    mse_reporter #(
        .NUM_SYS  (NS),
        .DATA_W   (DW),
        .BYTE_GAP (G),
        .HDR_BYTE (HDR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         cyc;
        logic [7:0] b;
    } ev_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    logic [DW-1:0] m_cap  [NS];
    logic          m_flag [NS];
    logic          m_ovr;
    logic [7:0]    m_last;
    int            m_idle_from;
    int            m_busy_lo;
    int            m_busy_hi;
    ev_t           exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NS; i++) begin
            m_cap[i]  = '0;
            m_flag[i] = 1'b0;
        end
        m_ovr       = 1'b0;
        m_last      = 8'h00;
        m_busy_lo   = 1;
        m_busy_hi   = 0;
        m_idle_from = cyc + 1;
        exp_q.delete();
    endtask

    task automatic check_outputs();
        logic busy_exp;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            m_last = exp_q[0].b;
            void'(exp_q.pop_front());
            check("txvalid", 64'(bus.com_txvalid), 64'd1);
        end else begin
            check("txvalid", 64'(bus.com_txvalid), 64'd0);
        end
        check("txdata", 64'(bus.com_txdata), 64'(m_last));
        busy_exp = (cyc >= m_busy_lo) && (cyc <= m_busy_hi);
        check("busy", 64'(bus.busy), 64'(busy_exp));
        check("overrun", 64'(bus.overrun), 64'(m_ovr));
    endtask

    // A frame starts in the first idle cycle that sees every flag set; its
    // bytes then follow at fixed G-cycle spacing starting the next cycle.
    task automatic model_step(input logic st, input logic [NS-1:0] v,
                              input logic [NS-1:0][DW-1:0] d);
        logic       all_set;
        logic       consume;
        logic [7:0] bytes[$];
        logic [7:0] cs;
        all_set = 1'b1;
        for (int i = 0; i < NS; i++) all_set &= m_flag[i];
        consume = all_set && (cyc >= m_idle_from);
        if (consume) begin
            cs = 8'h00;
            bytes.push_back(HDR);
            for (int i = 0; i < NS; i++)
                for (int b = DW/8 - 1; b >= 0; b--) begin
                    bytes.push_back(m_cap[i][8*b +: 8]);
                    cs ^= m_cap[i][8*b +: 8];
                end
            bytes.push_back(cs);
            for (int k = 0; k < FLEN; k++)
                exp_q.push_back('{cyc: cyc + 1 + k*G, b: bytes[k]});
            m_busy_lo   = cyc + 1;
            m_busy_hi   = cyc + FLEN*G;
            m_idle_from = cyc + 1 + FLEN*G;
        end
        for (int i = 0; i < NS; i++) begin
            if (st) begin
                m_flag[i] = 1'b0;
            end else if (v[i]) begin
                if (m_flag[i] && !consume) m_ovr = 1'b1;
                m_cap[i]  = d[i];
                m_flag[i] = 1'b1;
            end else if (consume) begin
                m_flag[i] = 1'b0;
            end
        end
        if (st) m_ovr = 1'b0;
    endtask

    // Entered at posedge+1; drives one cycle of inputs, checks, advances.
    task automatic step(input logic st, input logic [NS-1:0] v,
                        input logic [NS-1:0][DW-1:0] d);
        bus.start     = st;
        bus.mse_valid = v;
        bus.mse_data  = d;
        @(negedge clk);
        check_outputs();
        model_step(st, v, d);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0);
    endtask

    // Asserts rst mid-cycle and expects every output to drop before any edge.
    task automatic do_reset();
        bus.start     = 1'b0;
        bus.mse_valid = '0;
        bus.mse_data  = '0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_txvalid", 64'(bus.com_txvalid), 64'd0);
        check("rst_txdata", 64'(bus.com_txdata), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_overrun", 64'(bus.overrun), 64'd0);
        model_clear();
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NS-1:0]         v;
        logic [NS-1:0][DW-1:0] d;
        int                    rate;

        bus.start     = 1'b0;
        bus.mse_valid = '0;
        bus.mse_data  = '0;
        @(posedge clk);
        #1;
        do_reset();
        idle(100);

        // Basic frame: payload 0102 / 0304, checksum 04
        idle(9);
        step(1'b0, 2'b01, {64'h0, 64'h0102});
        idle(1);
        step(1'b0, 2'b10, {64'h0304, 64'h0});
        idle(80);

        // Simultaneous all-ones capture, checksum 00
        step(1'b0, 2'b11, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF});
        idle(80);

        // Overrun on sys0; frame carries the newer value
        step(1'b0, 2'b01, {64'h0, 64'h11});
        idle(2);
        step(1'b0, 2'b01, {64'h0, 64'h22});
        step(1'b0, 2'b10, {64'h33, 64'h0});
        idle(80);
        step(1'b1, 2'b00, '0);
        idle(3);

        // Double buffer: new set arrives during byte 5 of the running frame
        step(1'b0, 2'b11, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210});
        idle(1 + 5*G);
        step(1'b0, 2'b11, {64'hDEAD_BEEF_0000_0001, 64'h5555_AAAA_0F0F_F0F0});
        idle(2*FLEN*G + 10);

        // start together with valids drops them: no frame may follow
        step(1'b1, 2'b11, {64'h77, 64'h66});
        idle(20);

        // start mid-frame: frame completes, flags and overrun cleared
        step(1'b0, 2'b11, {64'h1111, 64'h2222});
        idle(2);
        step(1'b0, 2'b01, {64'h0, 64'h3333});
        idle(3*G);
        step(1'b1, 2'b00, '0);
        idle(FLEN*G + 10);

        // Reset mid-frame at byte 7
        step(1'b0, 2'b11, {64'hCAFE, 64'hBABE});
        idle(1 + 7*G);
        do_reset();
        idle(100);

        // Random traffic with varying arrival rates
        rate = 30;
        for (int n = 0; n < 4000; n++) begin
            if (n % 500 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rate = 3;
                    1:       rate = 30;
                    default: rate = 120;
                endcase
            end
            if ($urandom_range(0, 1999) == 0) begin
                do_reset();
            end else begin
                for (int i = 0; i < NS; i++) begin
                    v[i] = ($urandom_range(0, rate - 1) == 0);
                    d[i] = {$urandom, $urandom};
                end
                step(($urandom_range(0, 299) == 0), v, d);
            end
        end
        idle(FLEN*G + 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
